// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the byte-serialising memory controller.
// Goal codes, state encoding, request bundle and goal normalisation.
package memory_controller_pkg;

  localparam logic [2:0] GOAL_B = 3'd1;
  localparam logic [2:0] GOAL_H = 3'd2;
  localparam logic [2:0] GOAL_W = 3'd4;

  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  localparam logic [31:0] NULL_ADDR = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef struct packed {
    logic        lsb;
    logic        rw;
    logic [31:0] addr;
    logic [2:0]  goal;
    logic [31:0] data;
  } mc_req_t;

  // Byte and half pass through; every other code means a word.
  function automatic logic [2:0] norm_goal(
    input logic [2:0] g
  );
    if (g == GOAL_B || g == GOAL_H)
      return g;
    return GOAL_W;
  endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Core-side handshake bundle: fetch and load/store buffer channels.
// master = core (drives requests), slave = memory_controller.
interface memory_controller_if;

  logic        if_request_in;
  logic [31:0] if_address_in;
  logic        if_ready_out;
  logic [31:0] if_data_out;

  logic        lsb_request_in;
  logic        lsb_rw_signal_in;
  logic [31:0] lsb_address_in;
  logic [2:0]  lsb_goal_in;
  logic [31:0] lsb_data_in;
  logic        lsb_ready_out;
  logic [31:0] lsb_data_out;

  modport master (
    output if_request_in,
    output if_address_in,
    input  if_ready_out,
    input  if_data_out,
    output lsb_request_in,
    output lsb_rw_signal_in,
    output lsb_address_in,
    output lsb_goal_in,
    output lsb_data_in,
    input  lsb_ready_out,
    input  lsb_data_out
  );

  modport slave (
    input  if_request_in,
    input  if_address_in,
    output if_ready_out,
    output if_data_out,
    input  lsb_request_in,
    input  lsb_rw_signal_in,
    input  lsb_address_in,
    input  lsb_goal_in,
    input  lsb_data_in,
    output lsb_ready_out,
    output lsb_data_out
  );

endinterface

// File: rtl/memory_controller_arbiter.sv
// mc_arbiter: LSB pending slot plus fixed-priority request select.
// Ports: clk/rst, rollback, LSB pulse fields, fetch req, clear, sel_v/sel.
module mc_arbiter
  import memory_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rollback,
  input  logic        lsb_pulse,
  input  logic        lsb_rw,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_goal,
  input  logic [31:0] lsb_data,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        clear,
  output logic        sel_v,
  output mc_req_t     sel
);

  mc_req_t slot;
  mc_req_t pulse_req;
  mc_req_t fetch_req;
  logic    slot_v;
  logic    pulse_ok;
  logic    use_slot;
  logic    use_pulse;
  logic    use_if;

  // A flush kills loads only; stores are already committed.
  assign pulse_ok  = lsb_pulse & ~(rollback & ~lsb_rw);
  assign use_slot  = slot_v & ~(rollback & ~slot.rw);
  assign use_pulse = pulse_ok & ~use_slot;
  assign use_if    = if_req & ~rollback
                   & ~use_slot & ~pulse_ok;

  always_comb begin
    pulse_req      = '0;
    pulse_req.lsb  = 1'b1;
    pulse_req.rw   = lsb_rw;
    pulse_req.addr = lsb_addr;
    pulse_req.goal = norm_goal(lsb_goal);
    pulse_req.data = lsb_data;
  end

  always_comb begin
    fetch_req      = '0;
    fetch_req.addr = if_addr;
    fetch_req.goal = GOAL_W;
    fetch_req.data = ZERO_WORD;
  end

  always_comb begin
    sel_v = 1'b1;
    sel   = '0;
    unique case (1'b1)
      use_slot:  sel = slot;
      use_pulse: sel = pulse_req;
      use_if:    sel = fetch_req;
      default:   sel_v = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_v <= 1'b0;
      slot   <= '0;
    end else if (pulse_ok) begin
      slot_v <= 1'b1;
      slot   <= pulse_req;
    end else if (clear || (rollback && !slot.rw)) begin
      slot_v <= 1'b0;
    end
  end

endmodule

// File: rtl/memory_controller.sv
// Serialises fetch / load-store requests onto a byte-wide RAM/IO bus.
// Ports: clk, rst (sync, active-low), rob_rollback_in, bus (slave),
// mem_din/mem_dout/mem_a/mem_wr, io_buffer_full. Option: IO_STALL_EN.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rob_rollback_in,
  memory_controller_if.slave    bus,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  logic [1:0]  state;
  logic [2:0]  k;
  mc_req_t     cur;
  logic [31:0] result;
  logic [31:0] rd_word;
  logic [1:0]  kp;
  logic [7:0]  wr_byte;

  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;

  logic        if_ready_q;
  logic        lsb_ready_q;
  logic [31:0] if_data_q;
  logic [31:0] lsb_data_q;

  logic        sel_v;
  mc_req_t     sel;
  logic        in_io;
  logic        stall;
  logic        at_end;
  logic        finish;
  logic        clr;

  mc_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .rollback (rob_rollback_in),
    .lsb_pulse(bus.lsb_request_in),
    .lsb_rw   (bus.lsb_rw_signal_in),
    .lsb_addr (bus.lsb_address_in),
    .lsb_goal (bus.lsb_goal_in),
    .lsb_data (bus.lsb_data_in),
    .if_req   (bus.if_request_in),
    .if_addr  (bus.if_address_in),
    .clear    (clr),
    .sel_v    (sel_v),
    .sel      (sel)
  );

  assign in_io = (mem_a_q[17:16] == IO_BASE[17:16]);

`ifdef IO_STALL_EN
  // Byte on the bus targets a full UART: hold it off and freeze k.
  assign stall = (state == ST_WRITE) & mem_wr_q
               & in_io & io_buffer_full;
`else
  assign stall = 1'b0 & in_io & io_buffer_full;
`endif

  // Byte k-1 is on the bus while k is the next byte to issue.
  assign kp      = 2'(k - 3'd1);
  assign wr_byte = cur.data[{k[1:0], 3'b000} +: 8];
  assign at_end  = (k == cur.goal);
  assign finish  = at_end
                 & (((state == ST_READ) & ~rob_rollback_in)
                 | ((state == ST_WRITE) & ~stall));
  assign clr     = finish & cur.lsb;

  always_comb begin
    rd_word = result;
    rd_word[{kp, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      k           <= 3'd0;
      cur         <= '0;
      result      <= ZERO_WORD;
      mem_a_q     <= NULL_ADDR;
      mem_dout_q  <= 8'h00;
      mem_wr_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      if_data_q   <= ZERO_WORD;
      lsb_data_q  <= ZERO_WORD;
    end else begin
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          mem_a_q    <= NULL_ADDR;
          mem_dout_q <= 8'h00;
          mem_wr_q   <= 1'b0;
          if (sel_v) begin
            cur    <= sel;
            k      <= 3'd0;
            result <= ZERO_WORD;
            state  <= sel.rw ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          if (rob_rollback_in) begin
            state   <= ST_IDLE;
            mem_a_q <= NULL_ADDR;
          end else begin
            if (k != 3'd0)
              result <= rd_word;
            if (at_end) begin
              state   <= ST_IDLE;
              mem_a_q <= NULL_ADDR;
              if (cur.lsb) begin
                lsb_ready_q <= 1'b1;
                lsb_data_q  <= rd_word;
              end else begin
                if_ready_q <= 1'b1;
                if_data_q  <= rd_word;
              end
            end else begin
              mem_a_q <= cur.addr + {29'd0, k};
              k       <= k + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          if (!stall) begin
            if (at_end) begin
              state       <= ST_IDLE;
              mem_a_q     <= NULL_ADDR;
              mem_dout_q  <= 8'h00;
              mem_wr_q    <= 1'b0;
              lsb_ready_q <= 1'b1;
            end else begin
              mem_a_q    <= cur.addr + {29'd0, k};
              mem_dout_q <= wr_byte;
              mem_wr_q   <= 1'b1;
              k          <= k + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_a    = mem_a_q[ADDR_WIDTH-1:0];
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & ~stall;

  // A flush in the ready cycle swallows the fetch pulse.
  assign bus.if_ready_out  = if_ready_q & ~rob_rollback_in;
  assign bus.if_data_out   = if_data_q;
  assign bus.lsb_ready_out = lsb_ready_q;
  assign bus.lsb_data_out  = lsb_data_q;

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller.
// Table vectors, directed corner cases, random ops vs a byte-array model.
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rob = 1'b0;
  logic        io_full = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  memory_controller_if bus();

  memory_controller dut (
    .clk            (clk),
    .rst            (rst),
    .rob_rollback_in(rob),
    .bus            (bus),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_full)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:65535];
  logic [7:0]  mdl [0:65535];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  assign mem_din = ram[mem_a[15:0]];

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[15:0]] = mem_dout;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] g);
    if (g == 3'd1) return 1;
    if (g == 3'd2) return 2;
    return 4;
  endfunction

  // Reference: bytes addr..addr+n-1 (32-bit wrap), little-endian.
  task automatic model(input logic rw,
                       input logic [31:0] a,
                       input logic [2:0] g,
                       input logic [31:0] d,
                       output logic [31:0] exp);
    logic [31:0] ad;
    exp = 32'h0;
    for (int i = 0; i < nbytes(g); i++) begin
      ad = a + 32'(i);
      if (rw) mdl[ad[15:0]] = d[8*i +: 8];
      else exp[8*i +: 8] = mdl[ad[15:0]];
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a[15:0]] = b;
    mdl[a[15:0]] = b;
  endtask

  task automatic lsb_op(input logic rw,
                        input logic [31:0] a,
                        input logic [2:0] g,
                        input logic [31:0] d,
                        output logic [31:0] rd,
                        output int lat);
    @(negedge clk);
    bus.lsb_request_in   = 1'b1;
    bus.lsb_rw_signal_in = rw;
    bus.lsb_address_in   = a;
    bus.lsb_goal_in      = g;
    bus.lsb_data_in      = d;
    @(posedge clk); #1;
    bus.lsb_request_in = 1'b0;
    lat = -1;
    rd  = 32'hx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.lsb_ready_out) begin
        lat = c;
        rd  = bus.lsb_data_out;
        break;
      end
    end
  endtask

  task automatic fetch_op(input logic [31:0] a,
                          output logic [31:0] rd,
                          output int lat);
    @(negedge clk);
    bus.if_request_in = 1'b1;
    bus.if_address_in = a;
    @(posedge clk); #1;
    lat = -1;
    rd  = 32'hx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.if_ready_out) begin
        lat = c;
        rd  = bus.if_data_out;
        break;
      end
    end
    bus.if_request_in = 1'b0;
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] a;
    logic [2:0]  g;
    logic [31:0] d;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp;
    int lat;
    int lat_l;
    int lat_i;
    int nlog;
    int seen;
    int busy;
    logic [31:0] a;
    logic [2:0]  g;
    logic [31:0] d;
    logic        rw;

    bus.if_request_in    = 1'b0;
    bus.if_address_in    = 32'h0;
    bus.lsb_request_in   = 1'b0;
    bus.lsb_rw_signal_in = 1'b0;
    bus.lsb_address_in   = 32'h0;
    bus.lsb_goal_in      = 3'd0;
    bus.lsb_data_in      = 32'h0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'h00;
      mdl[i] = 8'h00;
    end
    poke(32'h100, 8'h13);
    poke(32'h3, 8'h80);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_ready", 32'(bus.if_ready_out), 0);
    chk("rst_lsb_ready", 32'(bus.lsb_ready_out), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_a", mem_a, 0);
    @(negedge clk);
    rst = 1'b1;

    nlog = wlog_a.size();
    fetch_op(32'h100, rd, lat);
    chk("fetch_data", rd, 32'h13);
    chk("fetch_lat", 32'(lat), 5);
    chk("fetch_no_wr", 32'(wlog_a.size()), 32'(nlog));

    tbl[0]  = '{1, 32'h200, 2, 32'hDEADBEEF, 0, 3};
    tbl[1]  = '{1, 32'h200, 4, 32'hDEADBEEF, 0, 5};
    tbl[2]  = '{0, 32'h200, 4, 0, 32'hDEADBEEF, 5};
    tbl[3]  = '{0, 32'h201, 2, 0, 32'h0000ADBE, 3};
    tbl[4]  = '{0, 32'h203, 1, 0, 32'h000000DE, 2};
    tbl[5]  = '{1, 32'h300, 2, 32'h12345678, 0, 3};
    tbl[6]  = '{0, 32'h300, 4, 0, 32'h00005678, 5};
    tbl[7]  = '{1, 32'h400, 3, 32'hA1B2C3D4, 0, 5};
    tbl[8]  = '{0, 32'h400, 0, 0, 32'hA1B2C3D4, 5};
    tbl[9]  = '{1, 32'h500, 1, 32'hFFFFFF80, 0, 2};
    tbl[10] = '{0, 32'h500, 1, 0, 32'h00000080, 2};
    tbl[11] = '{1, 32'hFFFFFFFF, 2, 32'h0000CAFE, 0, 3};
    tbl[12] = '{0, 32'hFFFFFFFF, 2, 0, 32'h0000CAFE, 3};

    wlog_a.delete();
    wlog_d.delete();
    for (int i = 0; i < 13; i++) begin
      model(tbl[i].rw, tbl[i].a, tbl[i].g, tbl[i].d, exp);
      lsb_op(tbl[i].rw, tbl[i].a, tbl[i].g, tbl[i].d, rd, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      if (!tbl[i].rw)
        chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
    end
    chk("wlog_size", 32'(wlog_a.size()), 15);
    if (wlog_a.size() == 15) begin
      chk("sh_b0_addr", wlog_a[0], 32'h200);
      chk("sh_b0_data", 32'(wlog_d[0]), 32'hEF);
      chk("sh_b1_addr", wlog_a[1], 32'h201);
      chk("sh_b1_data", 32'(wlog_d[1]), 32'hBE);
      chk("wrap_b0_addr", wlog_a[13], 32'hFFFFFFFF);
      chk("wrap_b1_addr", wlog_a[14], 32'h0);
      chk("wrap_b1_data", 32'(wlog_d[14]), 32'hCA);
    end

    // Same-cycle fetch and LB: LSB first, fetch sampled in its ready cycle.
    @(negedge clk);
    bus.if_request_in    = 1'b1;
    bus.if_address_in    = 32'h100;
    bus.lsb_request_in   = 1'b1;
    bus.lsb_rw_signal_in = 1'b0;
    bus.lsb_address_in   = 32'h3;
    bus.lsb_goal_in      = 3'd1;
    @(posedge clk); #1;
    bus.lsb_request_in = 1'b0;
    lat_l = -1;
    lat_i = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.lsb_ready_out) begin
        lat_l = c;
        chk("pri_lsb_data", bus.lsb_data_out, 32'h80);
      end
      if (bus.if_ready_out) begin
        lat_i = c;
        bus.if_request_in = 1'b0;
        chk("pri_if_data", bus.if_data_out, 32'h13);
        break;
      end
    end
    chk("pri_lsb_lat", 32'(lat_l), 2);
    chk("pri_if_lat", 32'(lat_i), 8);

    // Rollback while LW byte 1 is on the bus.
    @(negedge clk);
    bus.lsb_request_in   = 1'b1;
    bus.lsb_rw_signal_in = 1'b0;
    bus.lsb_address_in   = 32'h200;
    bus.lsb_goal_in      = 3'd4;
    @(posedge clk); #1;
    bus.lsb_request_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rb_byte1_addr", mem_a, 32'h201);
    @(negedge clk);
    rob = 1'b1;
    @(posedge clk); #1;
    rob = 1'b0;
    chk("rb_idle_addr", mem_a, 32'h0);
    seen = 0;
    busy = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.lsb_ready_out) seen++;
      if (mem_a != 32'h0) busy++;
    end
    chk("rb_no_ready", 32'(seen), 0);
    chk("rb_bus_quiet", 32'(busy), 0);

    // Rollback during a SW must not stop it.
    model(1, 32'h600, 4, 32'h11223344, exp);
    @(negedge clk);
    bus.lsb_request_in   = 1'b1;
    bus.lsb_rw_signal_in = 1'b1;
    bus.lsb_address_in   = 32'h600;
    bus.lsb_goal_in      = 3'd4;
    bus.lsb_data_in      = 32'h11223344;
    @(posedge clk); #1;
    bus.lsb_request_in = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 2) rob = 1'b1;
      if (c == 4) rob = 1'b0;
      if (bus.lsb_ready_out) begin
        lat = c;
        break;
      end
    end
    rob = 1'b0;
    chk("rb_sw_lat", 32'(lat), 5);
    model(0, 32'h600, 4, 0, exp);
    lsb_op(0, 32'h600, 4, 0, rd, lat);
    chk("rb_sw_data", rd, exp);

    // Reset in the middle of a LW.
    @(negedge clk);
    bus.lsb_request_in   = 1'b1;
    bus.lsb_rw_signal_in = 1'b0;
    bus.lsb_address_in   = 32'h200;
    bus.lsb_goal_in      = 3'd4;
    @(posedge clk); #1;
    bus.lsb_request_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_if_ready", 32'(bus.if_ready_out), 0);
    chk("mid_rst_if_data", bus.if_data_out, 0);
    chk("mid_rst_lsb_ready", 32'(bus.lsb_ready_out), 0);
    chk("mid_rst_lsb_data", bus.lsb_data_out, 0);
    chk("mid_rst_mem_a", mem_a, 0);
    chk("mid_rst_mem_dout", 32'(mem_dout), 0);
    chk("mid_rst_mem_wr", 32'(mem_wr), 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.lsb_ready_out || mem_a != 32'h0) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 0);
    fetch_op(32'h100, rd, lat);
    chk("post_rst_fetch", rd, 32'h13);
    chk("post_rst_lat", 32'(lat), 5);

    // SB into the IO window with the UART reporting full.
    nlog = wlog_a.size();
    @(negedge clk);
    io_full = 1'b1;
    bus.lsb_request_in   = 1'b1;
    bus.lsb_rw_signal_in = 1'b1;
    bus.lsb_address_in   = 32'h0003_0000;
    bus.lsb_goal_in      = 3'd1;
    bus.lsb_data_in      = 32'h0000_0041;
    @(posedge clk); #1;
    bus.lsb_request_in = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 4) io_full = 1'b0;
      if (bus.lsb_ready_out) begin
        lat = c;
        break;
      end
    end
    io_full = 1'b0;
`ifdef IO_STALL_EN
    chk("io_lat", 32'(lat), 5);
`else
    chk("io_lat", 32'(lat), 2);
`endif
    chk("io_wr_count", 32'(wlog_a.size() - nlog), 1);
    if (wlog_a.size() == nlog + 1) begin
      chk("io_wr_addr", wlog_a[nlog], 32'h0003_0000);
      chk("io_wr_data", 32'(wlog_d[nlog]), 32'h41);
    end

    // Random traffic against the byte-array model.
    for (int i = 0; i < 200; i++) begin
      a = 32'h1000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        model(0, a, 4, 0, exp);
        fetch_op(a, rd, lat);
        chk($sformatf("rnd%0d_if_data", i), rd, exp);
        chk($sformatf("rnd%0d_if_lat", i), 32'(lat), 5);
      end else begin
        rw = 1'($urandom_range(0, 1));
        g  = 3'($urandom_range(0, 7));
        d  = $urandom;
        model(rw, a, g, d, exp);
        lsb_op(rw, a, g, d, rd, lat);
        chk($sformatf("rnd%0d_lat", i), 32'(lat),
            32'(nbytes(g) + 1));
        if (!rw)
          chk($sformatf("rnd%0d_data", i), rd, exp);
      end
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
